hsid_mse_gen: RTL and testbench

HSID_MSE_GEN -- requirements
Module: hsid_mse_gen

---
 rtl/hsid_pkg.sv | 26 ++
 rtl/hsid_div.sv | 67 ++++++
 rtl/hsid_mse_gen.sv | 143 ++++++++++++++
 tb/tb_hsid_mse_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hsid_pkg.sv
// Shared HSID constants and the MSE generator state type.
// The state list depends on the HSID_MSE_DIV_EN macro: the DIV state
// exists only when the serial divider is built.
package hsid_pkg;

   localparam int unsigned HSID_WORD_WIDTH      = 32;
   localparam int unsigned HSID_DATA_WIDTH      = 16;
   localparam int unsigned HSID_MAX_BANDS       = 16;
   localparam int unsigned HSID_MAX_HSP_LIBRARY = 16;

`ifdef HSID_MSE_DIV_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DIV  = 2'd2,
      OUT  = 2'd3
   } hsid_mse_gen_state_t;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd3
   } hsid_mse_gen_state_t;
`endif

endpackage

// File: rtl/hsid_div.sv
// Serial restoring divider producing one quotient bit per clock.
// start loads the operands. After WIDTH step cycles, done pulses for one
// cycle and quotient holds dividend/divisor, truncated toward zero.
// abort cancels a division that is running.
module hsid_div #(
   parameter int unsigned WIDTH = 36
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);

   localparam int unsigned STEP_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]  rem;
   logic [WIDTH-1:0]  den;
   logic [STEP_W-1:0] steps;
   logic              running;
   logic [WIDTH:0]    trial;
   logic              fits;

   // The dividend's next bit is shifted into the remainder, then the trial subtraction is tested.
   always_comb begin
      trial = {rem, quotient[WIDTH-1]};
      fits  = (trial >= {1'b0, den});
   end

   // One restoring step per cycle. The quotient register also acts as the dividend shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         den      <= '0;
         quotient <= '0;
         steps    <= '0;
         running  <= 1'b0;
         done     <= 1'b0;
      end else if (abort) begin
         running <= 1'b0;
         done    <= 1'b0;
      end else if (start) begin
         rem      <= '0;
         den      <= divisor;
         quotient <= dividend;
         steps    <= STEP_W'(WIDTH);
         running  <= 1'b1;
         done     <= 1'b0;
      end else if (running) begin
         rem      <= fits ? WIDTH'(trial - {1'b0, den}) : trial[WIDTH-1:0];
         quotient <= {quotient[WIDTH-2:0], fits};
         steps    <= steps - 1'b1;
         if (steps == STEP_W'(1)) begin
            running <= 1'b0;
            done    <= 1'b1;
         end else begin
            done <= 1'b0;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/hsid_mse_gen.sv
// Mean squared error generator. It accumulates (a-b)^2 over the bands of
// one vector and emits a single-cycle result strobe with the library ref.
// Optional feature macro: HSID_MSE_DIV_EN.
//   Defined:   the result is sum/count from hsid_div.
//   Undefined: the result is the raw sum, saturated to WORD_WIDTH bits.
module hsid_mse_gen
   import hsid_pkg::*;
#(
   parameter  int unsigned WORD_WIDTH            = HSID_WORD_WIDTH,
   parameter  int unsigned DATA_WIDTH            = HSID_DATA_WIDTH,
   parameter  int unsigned HSI_BANDS             = HSID_MAX_BANDS,
   parameter  int unsigned HSI_LIBRARY_SIZE      = HSID_MAX_HSP_LIBRARY,
   localparam int unsigned HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic                             element_valid,
   output logic                             element_ready,
   input  logic                             element_last,
   input  logic [DATA_WIDTH-1:0]            element_a,
   input  logic [DATA_WIDTH-1:0]            element_b,
   input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] element_ref,
   output logic                             mse_out_valid,
   output logic [WORD_WIDTH-1:0]            mse_out_value,
   output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_out_ref,
   output logic                             busy
);

   localparam int unsigned ACC_WIDTH = 2 * DATA_WIDTH + $clog2(HSI_BANDS);
   localparam int unsigned CNT_WIDTH = $clog2(HSI_BANDS + 1);
   localparam logic [WORD_WIDTH-1:0] WORD_MAX = '1;

   hsid_mse_gen_state_t              state;
   logic [ACC_WIDTH-1:0]             sum;
   logic [CNT_WIDTH-1:0]             count;
   logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_q;

   logic signed [DATA_WIDTH:0]       diff;
   logic signed [2*DATA_WIDTH+1:0]   sq_full;
   logic [ACC_WIDTH-1:0]             sum_next;
   logic [CNT_WIDTH-1:0]             count_inc;
   logic                             hs;
   logic                             vec_end;

   function automatic logic [WORD_WIDTH-1:0] sat(input logic [ACC_WIDTH-1:0] x);
      if (x > ACC_WIDTH'(WORD_MAX)) return WORD_MAX;
      return x[WORD_WIDTH-1:0];
   endfunction

   // Handshake qualification and the per-band square term.
   always_comb begin
      diff      = $signed({1'b0, element_a}) - $signed({1'b0, element_b});
      sq_full   = diff * diff;
      sum_next  = sum + ACC_WIDTH'(sq_full);
      count_inc = count + 1'b1;
      hs        = element_valid && element_ready && !clear;
      vec_end   = element_last || (count_inc == CNT_WIDTH'(HSI_BANDS));
   end

   // The ready and busy outputs are decoded directly from the state register.
   always_comb begin
      element_ready = (state == IDLE) || (state == ACC);
      busy          = (state != IDLE);
   end

`ifdef HSID_MSE_DIV_EN
   logic                 div_done;
   logic [ACC_WIDTH-1:0] div_quot;

   // The divider loads on the edge that accepts the final band.
   // It therefore takes the updated sum and count directly.
   hsid_div #(.WIDTH(ACC_WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .abort    (clear),
      .start    (hs && vec_end),
      .dividend (sum_next),
      .divisor  (ACC_WIDTH'(count_inc)),
      .done     (div_done),
      .quotient (div_quot)
   );
`endif

   // Control FSM: accumulate, optionally divide, then emit one result strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         sum           <= '0;
         count         <= '0;
         ref_q         <= '0;
         mse_out_valid <= 1'b0;
         mse_out_value <= '0;
         mse_out_ref   <= '0;
      end else begin
         mse_out_valid <= 1'b0;
         if (clear) begin
            state <= IDLE;
            sum   <= '0;
            count <= '0;
         end else begin
            case (state)
               IDLE, ACC: begin
                  if (hs) begin
                     sum   <= sum_next;
                     count <= count_inc;
                     if (count == '0) ref_q <= element_ref;
                     if (vec_end) begin
`ifdef HSID_MSE_DIV_EN
                        state <= DIV;
`else
                        state         <= OUT;
                        mse_out_valid <= 1'b1;
                        mse_out_value <= sat(sum_next);
                        mse_out_ref   <= (count == '0) ? element_ref : ref_q;
`endif
                     end else begin
                        state <= ACC;
                     end
                  end
               end
`ifdef HSID_MSE_DIV_EN
               DIV: begin
                  if (div_done) begin
                     state         <= OUT;
                     mse_out_valid <= 1'b1;
                     mse_out_value <= sat(div_quot);
                     mse_out_ref   <= ref_q;
                  end
               end
`endif
               OUT: begin
                  state <= IDLE;
                  sum   <= '0;
                  count <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hsid_mse_gen.sv
// Self-checking bench for hsid_mse_gen, with directed cases and random vectors.
// The expected results come from a behavioural model: the mean, or the sum
// when HSID_MSE_DIV_EN is undefined, of the squared band differences.
module tb_hsid_mse_gen;
   import hsid_pkg::*;

   localparam int DW   = HSID_DATA_WIDTH;
   localparam int WW   = HSID_WORD_WIDTH;
   localparam int NB   = HSID_MAX_BANDS;
   localparam int AW   = $clog2(HSID_MAX_HSP_LIBRARY);
   localparam int ACCW = 2 * DW + $clog2(NB);
`ifdef HSID_MSE_DIV_EN
   localparam int LAT  = ACCW + 1;
`else
   localparam int LAT  = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, clear, element_valid, element_ready, element_last;
   logic [DW-1:0] element_a, element_b;
   logic [AW-1:0] element_ref, mse_out_ref;
   logic          mse_out_valid, busy;
   logic [WW-1:0] mse_out_value;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   logic [DW-1:0] va [NB];
   logic [DW-1:0] vb [NB];
   logic [WW-1:0] last_obs;
   logic [AW-1:0] last_obs_ref;

   hsid_mse_gen dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .element_valid(element_valid), .element_ready(element_ready),
      .element_last(element_last), .element_a(element_a), .element_b(element_b),
      .element_ref(element_ref), .mse_out_valid(mse_out_valid),
      .mse_out_value(mse_out_value), .mse_out_ref(mse_out_ref), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && mse_out_valid) pulses <= pulses + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] model(input int n);
      longint unsigned s = 0;
      for (int i = 0; i < n; i++) begin
         longint d = longint'(va[i]) - longint'(vb[i]);
         s += longint'(d * d);
      end
`ifdef HSID_MSE_DIV_EN
      s = s / longint'(n);
`endif
      if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
      return s[WW-1:0];
   endfunction

   // Drive n bands starting at posedge+1. The ref on later bands is random noise.
   task automatic send_vec(input int n, input bit use_last, input logic [AW-1:0] r0, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         element_valid = 1'b1;
         element_a     = va[i];
         element_b     = vb[i];
         element_ref   = (i == 0) ? r0 : AW'($urandom);
         element_last  = use_last && (i == n - 1);
         check("ready_in", {63'd0, element_ready}, 64'd1);
         @(posedge clk); #1;
         element_valid = 1'b0;
         element_last  = 1'b0;
      end
   endtask

   // Called at handshake edge + 1: measure the latency and check the single result pulse.
   task automatic expect_result(input string tag, input logic [WW-1:0] ev, input logic [AW-1:0] er);
      int k = 0;
      check({tag, "_ready_low"}, {63'd0, element_ready}, 64'd0);
      while (!mse_out_valid && k < LAT + 20) begin @(posedge clk); #1; k++; end
      check({tag, "_latency"}, 64'(k), 64'(LAT));
      check({tag, "_value"}, 64'(mse_out_value), 64'(ev));
      check({tag, "_ref"}, 64'(mse_out_ref), 64'(er));
      last_obs     = mse_out_value;
      last_obs_ref = mse_out_ref;
      @(posedge clk); #1;
      check({tag, "_pulse_end"}, {63'd0, mse_out_valid}, 64'd0);
      check({tag, "_hold"}, 64'(mse_out_value), 64'(ev));
      check({tag, "_idle"}, {62'd0, busy, element_ready}, 64'd1);
   endtask

   initial begin
      int p0;
      logic [WW-1:0] m_min, m_max, o_min, o_max;
      logic [AW-1:0] m_min_ref, o_min_ref;
      rst_n = 1'b0; clear = 1'b0; element_valid = 1'b0; element_last = 1'b0;
      element_a = '0; element_b = '0; element_ref = '0;
      #12;
      check("rst_outputs", {mse_out_valid, busy, element_ready, 4'(mse_out_ref), 32'(mse_out_value)},
            {25'd0, 3'b001, 36'd0});
      rst_n = 1'b1;
      @(posedge clk); #1;

      // The 4-band vector from the requirements.
      va[0] = 10; va[1] = 20; va[2] = 30; va[3] = 40;
      vb[0] = 12; vb[1] = 18; vb[2] = 30; vb[3] = 44;
      send_vec(4, 1'b1, 4'd5, 1'b0);
`ifdef HSID_MSE_DIV_EN
      expect_result("vec4", 32'd6, 4'd5);
`else
      expect_result("vec4", 32'd24, 4'd5);
`endif

      // Truncation case, then the single full-scale band.
      va[0] = 0; va[1] = 0; va[2] = 0; vb[0] = 1; vb[1] = 1; vb[2] = 0;
      send_vec(3, 1'b1, 4'd2, 1'b0);
`ifdef HSID_MSE_DIV_EN
      expect_result("trunc", 32'd0, 4'd2);
`else
      expect_result("trunc", 32'd2, 4'd2);
`endif
      va[0] = 16'hFFFF; vb[0] = 16'h0000;
      send_vec(1, 1'b1, 4'd9, 1'b0);
      expect_result("full1", 32'hFFFE_0001, 4'd9);

      // Forced completion when HSI_BANDS bands arrive with no last flag.
      for (int i = 0; i < NB; i++) begin va[i] = DW'(100 + i); vb[i] = DW'(3 * i); end
      send_vec(NB, 1'b0, 4'd11, 1'b0);
      expect_result("forced", model(NB), 4'd11);

      // Clear after two bands. The handshake in the same cycle must be discarded.
      p0 = pulses;
      va[0] = 50; va[1] = 60; vb[0] = 0; vb[1] = 0;
      send_vec(2, 1'b0, 4'd3, 1'b0);
      element_valid = 1'b1; element_a = 16'd999; element_b = 16'd0; element_last = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      element_valid = 1'b0; element_last = 1'b0; clear = 1'b0;
      check("clear_idle", {63'd0, busy}, 64'd0);
      va[0] = 3; vb[0] = 1;
      send_vec(1, 1'b1, 4'd7, 1'b0);
      expect_result("after_clear", 32'd4, 4'd7);
      check("clear_one_pulse", 64'(pulses - p0), 64'd1);

`ifdef HSID_MSE_DIV_EN
      // Clear during DIV must suppress the result.
      p0 = pulses;
      va[0] = 8; vb[0] = 1;
      send_vec(1, 1'b1, 4'd6, 1'b0);
      repeat (5) @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      check("clear_div_idle", {63'd0, busy}, 64'd0);
      repeat (LAT + 4) @(posedge clk);
      #1 check("clear_div_no_pulse", 64'(pulses - p0), 64'd0);
`endif

      // Asynchronous reset shortly after the final handshake, which lands in DIV when the divider is built.
      p0 = pulses;
      va[0] = 200; vb[0] = 1;
      send_vec(1, 1'b1, 4'd12, 1'b0);
`ifdef HSID_MSE_DIV_EN
      repeat (3) @(posedge clk);
      #1;
`endif
      #3 rst_n = 1'b0;
      #1 check("rst_mid", {mse_out_valid, busy, element_ready, 4'(mse_out_ref), 32'(mse_out_value)},
               {25'd0, 3'b001, 36'd0});
      #10 rst_n = 1'b1;
      repeat (LAT + 4) @(posedge clk);
      #1 check("rst_no_pulse", 64'(pulses - p0), 64'd0);

      // Random vectors with handshake gaps. The running min and max mimic the downstream comparator.
      m_min = '1; m_max = '0; o_min = '1; o_max = '0; m_min_ref = '0; o_min_ref = '0;
      for (int v = 0; v < 50; v++) begin
         int n;
         bit ul;
         logic [AW-1:0] r0;
         logic [WW-1:0] ev;
         n  = $urandom_range(1, NB);
         ul = (n < NB) ? 1'b1 : 1'($urandom_range(0, 1));
         r0 = AW'($urandom_range(0, HSID_MAX_HSP_LIBRARY - 1));
         for (int i = 0; i < n; i++) begin
            va[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : DW'($urandom);
            vb[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : DW'($urandom);
         end
         ev = model(n);
         send_vec(n, ul, r0, 1'b1);
         expect_result("rand", ev, r0);
         if (ev < m_min) begin m_min = ev; m_min_ref = r0; end
         if (ev > m_max) m_max = ev;
         if (last_obs < o_min) begin o_min = last_obs; o_min_ref = last_obs_ref; end
         if (last_obs > o_max) o_max = last_obs;
      end
      check("chain_min", 64'(o_min), 64'(m_min));
      check("chain_max", 64'(o_max), 64'(m_max));
      check("chain_min_ref", 64'(o_min_ref), 64'(m_min_ref));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
